// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// 800x600@60 Hz VGA timing generator (40 MHz pixel clock) for the wave display.
//
// A free-running horizontal/vertical counter pair produces the pixel position
// handed to the picture/wave ROM stage. That stage answers with an RGB565 pixel
// a fixed P_DATA_LAT clocks later. Sync and data-enable are delayed by the same
// amount, plus one more register, so that O_hsync, O_vsync, O_de and O_rgb all
// leave the block from registers in the same clock.
//
// Optional feature (compile-time macro VGA_TEST_PATTERN_EN):
//   When defined, I_pattern_en = 1 replaces I_data with eight 100-pixel-wide
//   colour bars. When undefined, I_pattern_en is ignored.
//
// Ports:
//   I_sys_clk      in   1   pixel clock (single clock domain)
//   I_reset_n      in   1   asynchronous active-low reset
//   O_pos_x        out 10   pixel column inside the visible area, else 0
//   O_pos_y        out 10   pixel row inside the visible area, else 0
//   O_pos_en       out  1   position is inside the visible area
//   O_frame_start  out  1   one-clock pulse at counter (0,0)
//   I_data         in  16   RGB565 pixel, valid P_DATA_LAT clocks after O_pos_*
//   I_pattern_en   in   1   select internal colour bars (macro build only)
//   O_hsync        out  1   horizontal sync, latency aligned
//   O_vsync        out  1   vertical sync, latency aligned
//   O_de           out  1   data enable, latency aligned
//   O_rgb          out 16   RGB565 output pixel, 0 when O_de = 0
//
// Handshake: there is no flow control. Every clock after the run flag sets is
// one pixel slot; O_pos_en marks slots whose I_data (P_DATA_LAT clocks later)
// is consumed, and O_de marks slots whose O_rgb carries picture data.
//
// P_DATA_LAT legal range is 1..8.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int P_H_ACTIVE = 800,
   parameter int P_H_FP     = 40,
   parameter int P_H_SYNC   = 128,
   parameter int P_H_BP     = 88,
   parameter int P_V_ACTIVE = 600,
   parameter int P_V_FP     = 1,
   parameter int P_V_SYNC   = 4,
   parameter int P_V_BP     = 23,
   parameter int P_SYNC_POL = 1,
   parameter int P_DATA_LAT = 2
) (
   input  logic        I_sys_clk,
   input  logic        I_reset_n,
   output logic [9:0]  O_pos_x,
   output logic [9:0]  O_pos_y,
   output logic        O_pos_en,
   output logic        O_frame_start,
   input  logic [15:0] I_data,
   input  logic        I_pattern_en,
   output logic        O_hsync,
   output logic        O_vsync,
   output logic        O_de,
   output logic [15:0] O_rgb
);

   // --------------------------------------------------------------------------
   // Derived timing constants
   // --------------------------------------------------------------------------
   localparam int H_TOTAL = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;
   localparam int V_TOTAL = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT_END  = 11'(P_H_ACTIVE);
   localparam logic [10:0] HS_BEGIN   = 11'(P_H_ACTIVE + P_H_FP);
   localparam logic [10:0] HS_END     = 11'(P_H_ACTIVE + P_H_FP + P_H_SYNC);

   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT_END  = 10'(P_V_ACTIVE);
   localparam logic [9:0]  VS_BEGIN   = 10'(P_V_ACTIVE + P_V_FP);
   localparam logic [9:0]  VS_END     = 10'(P_V_ACTIVE + P_V_FP + P_V_SYNC);

   localparam logic SYNC_ON  = (P_SYNC_POL != 0);
   localparam logic SYNC_OFF = !SYNC_ON;

   // --------------------------------------------------------------------------
   // Run flag: low during reset, high from the first edge after release.
   // Holding the counters until it sets makes the first clock after release
   // the (0,0) frame-start clock.
   // --------------------------------------------------------------------------
   logic run_q;

   always_ff @(posedge I_sys_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Horizontal / vertical counters
   // --------------------------------------------------------------------------
   logic [10:0] h_cnt;
   logic [9:0]  v_cnt;

   always_ff @(posedge I_sys_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (run_q) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
               v_cnt <= '0;
            end else begin
               v_cnt <= v_cnt + 10'd1;
            end
         end else begin
            h_cnt <= h_cnt + 11'd1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Position decode (zero latency from the counter registers)
   // --------------------------------------------------------------------------
   logic active;
   logic hs_raw;
   logic vs_raw;

   always_comb begin
      active        = run_q && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
      hs_raw        = run_q && (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
      vs_raw        = run_q && (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
      O_pos_en      = active;
      O_pos_x       = active ? h_cnt[9:0] : 10'd0;
      O_pos_y       = active ? v_cnt      : 10'd0;
      O_frame_start = run_q && (h_cnt == 11'd0) && (v_cnt == 10'd0);
   end

   // --------------------------------------------------------------------------
   // Latency alignment.
   // Stage i holds the value from i+1 clocks ago. Sync pipes carry the pin
   // level (polarity already applied) so their last stage drives the pins
   // directly. de_pipe[P_DATA_LAT-1] is enable for the pixel whose I_data is
   // present this clock; de_pipe[P_DATA_LAT] lines up with O_rgb.
   // --------------------------------------------------------------------------
   logic [P_DATA_LAT:0] hs_pipe;
   logic [P_DATA_LAT:0] vs_pipe;
   logic [P_DATA_LAT:0] de_pipe;
   logic                hs_lvl;
   logic                vs_lvl;

   always_comb begin
      hs_lvl = hs_raw ? SYNC_ON : SYNC_OFF;
      vs_lvl = vs_raw ? SYNC_ON : SYNC_OFF;
   end

   always_ff @(posedge I_sys_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         hs_pipe <= {(P_DATA_LAT + 1){SYNC_OFF}};
         vs_pipe <= {(P_DATA_LAT + 1){SYNC_OFF}};
         de_pipe <= '0;
      end else begin
         hs_pipe <= {hs_pipe[P_DATA_LAT-1:0], hs_lvl};
         vs_pipe <= {vs_pipe[P_DATA_LAT-1:0], vs_lvl};
         de_pipe <= {de_pipe[P_DATA_LAT-1:0], active};
      end
   end

   logic de_at_data;
   assign de_at_data = de_pipe[P_DATA_LAT-1];

   // --------------------------------------------------------------------------
   // Pixel source selection
   // --------------------------------------------------------------------------
   logic [15:0] pix_src;

`ifdef VGA_TEST_PATTERN_EN
   // Column delayed to line up with I_data, so the bars land on the same
   // pixels the ROM data would have.
   logic [9:0] x_pipe [P_DATA_LAT];

   always_ff @(posedge I_sys_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         for (int i = 0; i < P_DATA_LAT; i++) begin
            x_pipe[i] <= '0;
         end
      end else begin
         x_pipe[0] <= O_pos_x;
         for (int i = 1; i < P_DATA_LAT; i++) begin
            x_pipe[i] <= x_pipe[i-1];
         end
      end
   end

   // Bar index is x / 100; a compare ladder avoids a divider.
   function automatic logic [15:0] bar_colour(input logic [9:0] x);
      if      (x < 10'd100) return 16'hFFFF;
      else if (x < 10'd200) return 16'hFFE0;
      else if (x < 10'd300) return 16'h07FF;
      else if (x < 10'd400) return 16'h07E0;
      else if (x < 10'd500) return 16'hF81F;
      else if (x < 10'd600) return 16'hF800;
      else if (x < 10'd700) return 16'h001F;
      else                  return 16'h0000;
   endfunction

   always_comb begin
      pix_src = I_data;
      if (I_pattern_en) begin
         pix_src = bar_colour(x_pipe[P_DATA_LAT-1]);
      end
   end
`else
   logic unused_pattern_en;
   assign unused_pattern_en = I_pattern_en;

   always_comb begin
      pix_src = I_data;
   end
`endif

   // --------------------------------------------------------------------------
   // Output pixel register: picture data only when the delayed enable is set,
   // so blanking always reads as black regardless of what I_data carries.
   // --------------------------------------------------------------------------
   logic [15:0] rgb_q;

   always_ff @(posedge I_sys_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         rgb_q <= '0;
      end else begin
         rgb_q <= de_at_data ? pix_src : 16'h0000;
      end
   end

   assign O_hsync = hs_pipe[P_DATA_LAT];
   assign O_vsync = vs_pipe[P_DATA_LAT];
   assign O_de    = de_pipe[P_DATA_LAT];
   assign O_rgb   = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Horizontal timing uses the full 800x600 line; the frame is shortened to a
// few lines so several complete frames fit in a short run.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int HA  = 800;
   localparam int HF  = 40;
   localparam int HS  = 128;
   localparam int HB  = 88;
   localparam int VA  = 8;
   localparam int VF  = 1;
   localparam int VS  = 4;
   localparam int VB  = 3;
   localparam int POL = 1;
   localparam int LAT = 2;

   localparam int HT    = HA + HF + HS + HB;
   localparam int VT    = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;

   localparam logic SYNC_ON  = (POL != 0);
   localparam logic SYNC_OFF = !SYNC_ON;
   localparam logic [18:0] IDLE = {1'b0, SYNC_OFF, SYNC_OFF, 16'h0000};

   // ---------------------------------------------------------------- clock/reset
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] i_data = 16'h0000;
   logic        pat_en = 1'b0;

   logic [9:0]  o_pos_x;
   logic [9:0]  o_pos_y;
   logic        o_pos_en;
   logic        o_frame_start;
   logic        o_hsync;
   logic        o_vsync;
   logic        o_de;
   logic [15:0] o_rgb;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .P_H_ACTIVE (HA),
      .P_H_FP     (HF),
      .P_H_SYNC   (HS),
      .P_H_BP     (HB),
      .P_V_ACTIVE (VA),
      .P_V_FP     (VF),
      .P_V_SYNC   (VS),
      .P_V_BP     (VB),
      .P_SYNC_POL (POL),
      .P_DATA_LAT (LAT)
   ) dut (
      .I_sys_clk     (clk),
      .I_reset_n     (rst_n),
      .O_pos_x       (o_pos_x),
      .O_pos_y       (o_pos_y),
      .O_pos_en      (o_pos_en),
      .O_frame_start (o_frame_start),
      .I_data        (i_data),
      .I_pattern_en  (pat_en),
      .O_hsync       (o_hsync),
      .O_vsync       (o_vsync),
      .O_de          (o_de),
      .O_rgb         (o_rgb)
   );

   // ---------------------------------------------------------------- scoreboard
   int compared = 0;
   int mismatched = 0;
   int n = -2;                 // pixel clock index since release (-1 = pre-run)
   logic [18:0] exp_q[$];      // {de, hsync, vsync, rgb} for the next clock

`ifdef VGA_TEST_PATTERN_EN
   logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`endif

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // ---------------------------------------------------------------- reference model + ROM driver
   always @(negedge clk) begin : model
      int h, v, q, hq, vq;
      logic act, act_q, hs_e, vs_e;
      logic [15:0] exp_rgb;
      if (!rst_n) begin
         n = -2;
         exp_q.delete();
         i_data = 16'($urandom);
      end else begin
         n++;
         if (n == -1) begin
            check("pos_prerun", {o_pos_en, o_frame_start, o_pos_y, o_pos_x}, 22'd0);
            i_data = 16'($urandom);
            exp_q.push_back(IDLE);
         end else begin
            h   = n % HT;
            v   = (n / HT) % VT;
            act = (h < HA) && (v < VA);
            check("pos", {o_pos_en, o_frame_start, o_pos_y, o_pos_x},
                  {act, (h == 0 && v == 0), act ? 10'(v) : 10'd0, act ? 10'(h) : 10'd0});

            if ($urandom_range(0, 63) == 0) pat_en = ~pat_en;

            // Pixel whose data the ROM returns this clock, shown next clock.
            q = n - LAT;
            if (q < 0) begin
               i_data = 16'($urandom);
               exp_q.push_back(IDLE);
            end else begin
               hq    = q % HT;
               vq    = (q / HT) % VT;
               act_q = (hq < HA) && (vq < VA);
               if (act_q) i_data = {vq[5:0], hq[9:0]};
               else       i_data = 16'($urandom);
               exp_rgb = 16'h0000;
               if (act_q) begin
                  exp_rgb = i_data;
`ifdef VGA_TEST_PATTERN_EN
                  if (pat_en) exp_rgb = bars[hq / 100];
`endif
               end
               hs_e = (hq >= HA + HF && hq < HA + HF + HS) ? SYNC_ON : SYNC_OFF;
               vs_e = (vq >= VA + VF && vq < VA + VF + VS) ? SYNC_ON : SYNC_OFF;
               exp_q.push_back({act_q, hs_e, vs_e, exp_rgb});
            end
         end
      end
   end

   // ---------------------------------------------------------------- monitor
   logic started = 1'b0;
   logic de_prev, hs_prev, vs_prev;
   logic de_fell_once, vs_seen, fs_seen;
   int   de_hi, de_lo, since_fall, hs_len, vs_len, de_frame, fs_gap;

   always @(negedge clk) begin : monitor
      logic [18:0] e;
      logic hs_now, vs_now;
      if (!rst_n) begin
         check("reset_out", {o_pos_x, o_pos_y, o_pos_en, o_frame_start, o_de, o_hsync, o_vsync, o_rgb},
               {10'd0, 10'd0, 1'b0, 1'b0, IDLE});
         started = 1'b0;
         de_prev = 1'b0; hs_prev = 1'b0; vs_prev = 1'b0;
         de_fell_once = 1'b0; vs_seen = 1'b0; fs_seen = 1'b0;
         de_hi = 0; de_lo = 0; since_fall = 0; hs_len = 0; vs_len = 0; de_frame = 0; fs_gap = 0;
      end else if (!started) begin
         started = 1'b1;
         check("prerun_out", {o_de, o_hsync, o_vsync, o_rgb}, IDLE);
      end else begin
         if (exp_q.size() == 0) begin
            check("queue_empty", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("pixel_out", {o_de, o_hsync, o_vsync, o_rgb}, e);
         end

         hs_now = (o_hsync == SYNC_ON);
         vs_now = (o_vsync == SYNC_ON);

         // data enable run lengths
         if (o_de) begin
            if (!de_prev) begin
               if (de_fell_once)
                  check("de_low", de_lo, (de_lo > HT) ? HT * (VT - VA) + HT - HA : HT - HA);
               de_hi = 0;
            end
            de_hi++;
            de_frame++;
         end else begin
            if (de_prev) begin
               check("de_high", de_hi, HA);
               de_fell_once = 1'b1;
               de_lo = 0;
            end
            de_lo++;
         end
         if (de_prev && !o_de) since_fall = 0;
         else                  since_fall++;

         // hsync placement and width
         if (hs_now && !hs_prev) begin
            if (de_fell_once && since_fall < HT) check("hs_delay", since_fall, HF);
            hs_len = 0;
         end
         if (hs_now) hs_len++;
         if (!hs_now && hs_prev) check("hs_width", hs_len, HS);

         // vsync width and enable count per frame
         if (vs_now && !vs_prev) begin
            if (vs_seen) check("frame_de", de_frame, HA * VA);
            de_frame = 0;
            vs_seen  = 1'b1;
            vs_len   = 0;
         end
         if (vs_now) vs_len++;
         if (!vs_now && vs_prev) check("vs_width", vs_len, VS * HT);

         // frame start period
         fs_gap++;
         if (o_frame_start) begin
            if (fs_seen) check("frame_period", fs_gap, FRAME);
            fs_gap  = 0;
            fs_seen = 1'b1;
         end

         de_prev = o_de;
         hs_prev = hs_now;
         vs_prev = vs_now;
      end
   end

   // ---------------------------------------------------------------- driver
   task automatic wait_n(input int target, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if (n >= target) break;
         @(posedge clk);
      end
      check(name, (n >= target), 1'b1);
   endtask

   initial begin
      int i;
      rst_n  = 1'b0;
      pat_en = 1'($urandom_range(0, 1));
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b1;

      // Two full frames plus the vsync of a third.
      wait_n(2 * FRAME + (VA + VF + VS + 1) * HT, 3 * FRAME, "run_frames");

      // Reset pulse at line 5, column 500 of the next frame.
      for (i = 0; i < 2 * FRAME; i++) begin
         if (n >= 0 && (n % FRAME) == 5 * HT + 500) break;
         @(posedge clk);
      end
      check("reach_mid_frame", (n % FRAME), 5 * HT + 500);
      #2 rst_n = 1'b0;
      #1 check("async_reset", {o_pos_x, o_pos_y, o_pos_en, o_frame_start, o_de, o_hsync, o_vsync, o_rgb},
               {10'd0, 10'd0, 1'b0, 1'b0, IDLE});
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Restart from (0,0) and run a few lines.
      wait_n(3 * HT, 4 * HT, "run_after_reset");

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates 800x600@60 Hz VGA timing (40 MHz pixel clock) for the wave display.
- Drives pixel position and enable to the picture/wave ROM stage, which returns the 16-bit RGB565 pixel for that position.
- Re-times hsync, vsync and data-enable by the pixel stage's fixed latency, so sync and colour leave the block aligned on the same registered pins.

## Interface
Parameters:
- P_H_ACTIVE, 800, visible pixels per line
- P_H_FP, 40, horizontal front porch (clocks)
- P_H_SYNC, 128, hsync width (clocks)
- P_H_BP, 88, horizontal back porch (clocks)
- P_V_ACTIVE, 600, visible lines per frame
- P_V_FP, 1, vertical front porch (lines)
- P_V_SYNC, 4, vsync width (lines)
- P_V_BP, 23, vertical back porch (lines)
- P_SYNC_POL, 1, asserted sync level (1 = positive)
- P_DATA_LAT, 2, clocks from O_pos_* to valid I_data (legal range 1..8)

Ports:
- I_sys_clk  in  1  pixel clock; single clock domain
- I_reset_n  in  1  asynchronous, active-low reset
- O_pos_x  out  10  pixel column, 0..P_H_ACTIVE-1; 0 outside active
- O_pos_y  out  10  pixel row, 0..P_V_ACTIVE-1; 0 outside active
- O_pos_en  out  1  position is inside the visible area
- O_frame_start  out  1  one-clock pulse at counter (0,0)
- I_data  in  16  RGB565 pixel, valid P_DATA_LAT clocks after its O_pos_*
- I_pattern_en  in  1  selects the internal test pattern (see Configuration)
- O_hsync  out  1  horizontal sync, latency-aligned
- O_vsync  out  1  vertical sync, latency-aligned
- O_de  out  1  data enable, latency-aligned
- O_rgb  out  16  RGB565 output pixel; 0 when O_de = 0

## Operation
- Line and frame totals:
  - H_TOTAL = sum of the H parameters = 1056.
  - V_TOTAL = sum of the V parameters = 628.
- Run flag:
  - Cleared by reset; set on the first clock edge after reset release.
  - While clear, counters hold at 0 and all outputs sit at their reset values.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; v_cnt wraps to 0 after V_TOTAL-1.
  - Both wrap together at (H_TOTAL-1, V_TOTAL-1) -> (0,0).
- Active area: h_cnt < P_H_ACTIVE and v_cnt < P_V_ACTIVE.
  - Inside: O_pos_x = h_cnt, O_pos_y = v_cnt, O_pos_en = 1.
  - Outside: all three are 0.
- O_frame_start = 1 only while run = 1 and the counters are at (0,0).
- Raw hsync asserted for h_cnt in [P_H_ACTIVE+P_H_FP, P_H_ACTIVE+P_H_FP+P_H_SYNC), i.e. 840..967.
- Raw vsync asserted for v_cnt in [P_V_ACTIVE+P_V_FP, P_V_ACTIVE+P_V_FP+P_V_SYNC), i.e. 601..604, for whole lines.
- Raw hsync, raw vsync and O_pos_en each pass through a (P_DATA_LAT+1)-stage shift register to form O_hsync, O_vsync and O_de.
- O_rgb register, updated every clock:
  - Loads I_data when the de delayed by P_DATA_LAT stages is 1.
  - Loads 0 otherwise.
- Counter and sync widths: 11 bits horizontal, 10 bits vertical; comparisons are unsigned.

## Timing
- Reset values:
  - O_pos_x, O_pos_y = 0; O_pos_en, O_frame_start, O_de = 0; O_rgb = 0.
  - O_hsync and O_vsync = ~P_SYNC_POL.
  - All delay stages cleared to the deasserted level.
- O_pos_*, O_frame_start: combinational decode of counter registers; zero added latency.
- First O_frame_start is on the first clock after reset release, at the (0,0) count.
- Pixel issued on O_pos_* at cycle t:
  - I_data for it is sampled at cycle t+P_DATA_LAT.
  - It appears on O_rgb at t+P_DATA_LAT+1, together with its own O_de, O_hsync and O_vsync.
- Per-line and per-frame counts:
  - Line period 1056 clocks; frame period 663168 clocks.
  - 800 O_pos_en clocks per active line; 480000 per frame.
  - hsync 128 clocks; vsync 4224 clocks.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronous); timing restarts at (0,0) after release.
- I_data is ignored whenever the delayed de is 0.

## Configuration
- Macro VGA_TEST_PATTERN_EN.
- Defined:
  - When I_pattern_en = 1, O_rgb loads a colour-bar value instead of I_data, still gated by the delayed de.
  - The bar is chosen from the pixel column delayed by P_DATA_LAT (bar index = x / 100).
  - Bar colours, in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Not defined: I_pattern_en is ignored and O_rgb always follows I_data.

## Test plan
- Reset held, then released:
  - All outputs hold reset values during reset.
  - O_frame_start pulses on cycle 1 after release.
  - Next pulse exactly 663168 clocks later.
- One full line: count clocks on the delayed outputs.
  - O_de high 800 clocks, then low 256.
  - O_hsync at P_SYNC_POL for exactly 128 clocks, starting 40 clocks after O_de falls.
- One full frame: O_vsync asserted for lines 601..604 (4224 clocks); 480000 O_de clocks in total.
- Bench model returns I_data = {pos_y[5:0], pos_x[9:0]} with P_DATA_LAT latency: every O_rgb with O_de = 1 matches the model; O_rgb = 0 elsewhere.
- Reset pulsed at v_cnt = 300, h_cnt = 500: outputs drop to reset values asynchronously; after release, the position sequence restarts at (0,0).
- VGA_TEST_PATTERN_EN defined, I_pattern_en = 1:
  - Columns 0..99 give FFFF, 100..199 give FFE0, 700..799 give 0000.
  - With the macro undefined, the same stimulus gives the I_data model values.
